// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Contents: funct3 codes, FSM state encoding, DMEM select codes and the
// access legality check used at request accept.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // DMEM port is only ever used for whole-word accesses.
    localparam logic [1:0] WSEL_WORD = 2'b00;
    localparam logic [2:0] RSEL_WORD = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StErr
    } lsu_state_e;

    // True when the request must be rejected: illegal funct3 or misaligned address.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic err;
        err = 1'b0;
        if (we && (funct3 > F3_W)) begin
            err = 1'b1;
        end else begin
            case (funct3)
                F3_B, F3_BU: err = 1'b0;
                F3_H, F3_HU: err = lane[0];
                F3_W:        err = (lane != 2'b00);
                default:     err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath for the LSU (purely combinational).
// Ports:
//   word    in  32  word read from DMEM
//   wdata   in  32  store data (SB uses [7:0], SH uses [15:0])
//   lane    in  2   byte address bits [1:0]
//   funct3  in  3   access type; bits [1:0] give the store size
//   rdata   out 32  extracted, sign/zero-extended load data
//   merged  out 32  word with the store data written into its lane
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h000000, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0000, half_sel};
            F3_W:    rdata = word;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3[1:0])
            2'b00:   merged[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-addressed data memory.
// Loads: IDLE->RD->CAP->IDLE. Word stores: IDLE->WR->IDLE.
// Sub-word stores read-modify-write: IDLE->RD->CAP->WR->IDLE.
// Rejected requests: IDLE->ERR->IDLE with no memory cycle.
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata    request fields, latched at accept
//   rsp_valid/rsp_rdata/rsp_err one-cycle response pulse
//   mem_addr/wdata/we/wsel/rsel DMEM port (word access only)
//   mem_rdata                   DMEM read data, valid one cycle after the address
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [1:0]            mem_wsel,
    output logic [2:0]            mem_rsel,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    lsu_lane u_lane (
        .word   (mem_rdata),
        .wdata  (wdata_q),
        .lane   (lane_q),
        .funct3 (f3_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d       = req_we;
                    f3_d       = req_funct3;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (access_err(req_we, req_funct3, req_addr[1:0])) begin
                        state_d = StErr;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        // Full-word store needs no read; write straight away.
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                        state_d     = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                if (we_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = lane_merged;
                    state_d     = StWr;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_rdata;
                    state_d     = StIdle;
                end
            end
            StWr: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = StIdle;
            end
            StErr: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wsel  = WSEL_WORD;
    assign mem_rsel  = RSEL_WORD;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_wsel;
    logic [2:0]  mem_rsel;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    // DMEM environment: 256 words, registered read, synchronous word write.
    logic [31:0] dmem [0:255];
    // Reference memory image maintained from the access rules.
    logic [31:0] ref_mem [0:255];

    dmem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_wsel   (mem_wsel),
        .mem_rsel   (mem_rsel),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[9:2]];
    end

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input bit we, input int f3);
        if (we) return (f3 <= 2);
        return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    endfunction

    function automatic int ref_size(input int f3);
        if (f3 % 4 == 0) return 1;
        if (f3 % 4 == 1) return 2;
        return 4;
    endfunction

    function automatic bit ref_err(input bit we, input int f3, input int unsigned addr);
        if (!ref_legal(we, f3)) return 1'b1;
        return (addr % ref_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int f3,
                                             input int unsigned addr);
        int unsigned v;
        int unsigned sz;
        sz = ref_size(f3);
        if (sz == 4) return word;
        v = (word >> (8 * (addr % 4))) & ((sz == 1) ? 32'hFF : 32'hFFFF);
        if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
        if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input int f3,
                                              input int unsigned addr,
                                              input logic [31:0] data);
        int unsigned mask;
        int unsigned sh;
        if (ref_size(f3) == 4) return data;
        mask = (ref_size(f3) == 1) ? 32'hFF : 32'hFFFF;
        sh   = 8 * (addr % 4);
        return (word & ~(mask << sh)) | ((data & mask) << sh);
    endfunction

    function automatic int ref_latency(input bit we, input int f3, input int unsigned addr);
        if (ref_err(we, f3, addr)) return 2;
        if (!we) return 3;
        if (f3 == 2) return 2;
        return 4;
    endfunction

    // ---------------- request driver ----------------
    // Issues one request and collects what the DUT did until its response.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int we_pulses,
                          output logic [31:0] we_addr, output logic ready_at_rsp);
        bit seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; we_pulses = 0; we_addr = '0; seen = 0;
        rdata = 'x; err = 1'bx; ready_at_rsp = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_pulses++;
                we_addr = mem_addr;
            end
            if (rsp_valid) begin
                seen = 1;
                lat = c;
                rdata = rsp_rdata;
                err = rsp_err;
                ready_at_rsp = req_ready;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no rsp_valid within 12 cycles (addr=%h f3=%0d)", addr, f3);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got valid=%b err=%b want 0 0", rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got we=%b addr=%h wdata=%h want 0 0 0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (mem_wsel !== 2'b00 || mem_rsel !== 3'b000) begin
            errors++; $display("FAIL reset_sel got wsel=%b rsel=%b want 00 000", mem_wsel, mem_rsel);
        end
    endtask

    task automatic test_loads();
        logic [31:0] rd, wa; logic er, rdy; int lat, wp;
        logic [2:0] f3s [4]; logic [31:0] adr [4]; logic [31:0] exp [4];
        f3s = '{3'b000, 3'b101, 3'b001, 3'b010};
        adr = '{32'h41, 32'h42, 32'h42, 32'h40};
        exp = '{32'hFFFFFFAA, 32'h00008899, 32'hFFFF8899, 32'h8899AABB};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adr[i], 32'h0, rd, er, lat, wp, wa, rdy);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d got rdata=%h err=%b want %h 0", i, rd, er, exp[i]);
            end
            checks++;
            if (lat != 3 || wp != 0 || rdy !== 1'b1) begin
                errors++;
                $display("FAIL load_timing_%0d got lat=%0d we=%0d ready=%b want 3 0 1", i, lat, wp, rdy);
            end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd, wa; logic er, rdy; int lat, wp;
        do_req(1'b1, 3'b000, 32'h43, 32'hFFFFFF11, rd, er, lat, wp, wa, rdy);
        checks++;
        if (wp != 1 || lat != 4 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sb_handshake got we=%0d lat=%0d err=%b rdata=%h want 1 4 0 0", wp, lat, er, rd);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wp, wa, rdy);
        checks++;
        if (rd !== 32'h1199AABB) begin errors++; $display("FAIL sb_readback got %h want 1199aabb", rd); end
        do_req(1'b1, 3'b001, 32'h40, 32'hABCD1234, rd, er, lat, wp, wa, rdy);
        checks++;
        if (wp != 1 || lat != 4) begin
            errors++; $display("FAIL sh_handshake got we=%0d lat=%0d want 1 4", wp, lat);
        end
        do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, wp, wa, rdy);
        checks++;
        if (rd !== 32'h11991234) begin errors++; $display("FAIL sh_readback got %h want 11991234", rd); end
    endtask

    task automatic test_word_store();
        logic [31:0] rd, wa; logic er, rdy; int lat, wp;
        do_req(1'b1, 3'b010, 32'h80, 32'hDEADBEEF, rd, er, lat, wp, wa, rdy);
        checks++;
        if (wp != 1 || wa !== 32'h80 || lat != 2) begin
            errors++;
            $display("FAIL sw_handshake got we=%0d addr=%h lat=%0d want 1 00000080 2", wp, wa, lat);
        end
        do_req(1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat, wp, wa, rdy);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_readback got %h want deadbeef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, wa; logic er, rdy; int lat, wp;
        logic we_s [3]; logic [2:0] f3s [3]; logic [31:0] adr [3];
        we_s = '{1'b0, 1'b1, 1'b0};
        f3s  = '{3'b010, 3'b001, 3'b011};
        adr  = '{32'h42, 32'h41, 32'h40};
        for (int i = 0; i < 3; i++) begin
            do_req(we_s[i], f3s[i], adr[i], 32'hFFFFFFFF, rd, er, lat, wp, wa, rdy);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || wp != 0 || lat != 2) begin
                errors++;
                $display("FAIL err_%0d got err=%b rdata=%h we=%0d lat=%0d want 1 0 0 2",
                         i, er, rd, wp, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wa, wd, exp_rd; logic er, rdy; int lat, wp, f3, exp_lat;
        bit we, exp_err; int unsigned addr;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = $urandom_range(0, 7);
            addr = 32'h100 + $urandom_range(0, 255);
            if ($urandom_range(0, 2) != 0) addr = addr & ~(ref_size(f3) - 1);
            wd   = $urandom;
            exp_err = ref_err(we, f3, addr);
            exp_lat = ref_latency(we, f3, addr);
            exp_rd  = (!we && !exp_err) ? ref_load(ref_mem[addr / 4 % 256], f3, addr) : 32'h0;
            do_req(we, 3'(f3), addr, wd, rd, er, lat, wp, wa, rdy);
            if (we && !exp_err) ref_mem[addr / 4 % 256] = ref_store(ref_mem[addr / 4 % 256], f3, addr, wd);
            checks++;
            if (rd !== exp_rd || er !== exp_err || lat != exp_lat
                || wp != ((we && !exp_err) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand_%0d we=%0d f3=%0d addr=%h got rdata=%h err=%b lat=%0d wes=%0d want %h %b %0d",
                         n, we, f3, addr, rd, er, lat, wp, exp_rd, exp_err, exp_lat);
            end
        end
        for (int i = 64; i < 128; i++) begin
            checks++;
            if (dmem[i] !== ref_mem[i]) begin
                errors++; $display("FAIL rand_mem word %0d got %h want %h", i, dmem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int bad_rsp, bad_we;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h44; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;  // LSU is in CAP here
        #1;
        checks++;
        if (mem_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got we=%b ready=%b valid=%b want 0 1 0", mem_we, req_ready, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bad_rsp = 0; bad_we = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp++;
            if (mem_we) bad_we++;
        end
        checks++;
        if (bad_rsp != 0 || bad_we != 0) begin
            errors++; $display("FAIL rst_mid_after got rsp=%0d we=%0d want 0 0", bad_rsp, bad_we);
        end
        checks++;
        if (dmem[32'h44 / 4] !== 32'h55667788) begin
            errors++; $display("FAIL rst_mid_mem got %h want 55667788", dmem[32'h44 / 4]);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[32'h40 / 4] = 32'h8899AABB;
        dmem[32'h44 / 4] = 32'h55667788;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_loads();
        test_subword_store();
        test_word_store();
        test_errors();
        test_random();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
